fetch_sequencer: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences instruction-memory reads for the single-issue CPU. It issues reads over a READ/BUSYWAIT handshake and presents one instruction at a time to decode. It speculatively prefetches PC+4 while the current instruction executes, and resolves JUMP/BEQ/BNE redirects, discarding stale prefetches. It sits between instruction memory and the decode/control unit and replaces a free-running PC register.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 31 +++
 rtl/fetch_sequencer_next_pc_calc.sv | 44 ++++
 rtl/fetch_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer: the FSM state
// encoding and the PC arithmetic constants used by the top level and by
// the next-PC calculator.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        EXEC_BUF,
        DRAIN
    } fetch_state_t;

    localparam int PC_RESET     = 0;   // first instruction address after reset
    localparam int PC_STEP      = 4;   // bytes per instruction word
    localparam int OFFSET_SHIFT = 2;   // branch/jump offsets are in words

endpackage

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
// Instruction-memory read bus between the fetch sequencer and instruction
// memory.
//   IMEM_READ      read request, held high until the read completes
//   IMEM_ADDR      read address, stable while IMEM_READ is high
//   IMEM_BUSYWAIT  memory busy; a read completes on an edge with READ=1, BUSYWAIT=0
//   IMEM_RDATA     read data, valid on the completing edge
// master: the fetch sequencer; slave: the instruction memory.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               IMEM_READ;
    logic [ADDR_W-1:0]  IMEM_ADDR;
    logic               IMEM_BUSYWAIT;
    logic [INSTR_W-1:0] IMEM_RDATA;

    modport master (
        output IMEM_READ,
        output IMEM_ADDR,
        input  IMEM_BUSYWAIT,
        input  IMEM_RDATA
    );

    modport slave (
        input  IMEM_READ,
        input  IMEM_ADDR,
        output IMEM_BUSYWAIT,
        output IMEM_RDATA
    );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// next_pc_calc
// Purely combinational next-PC arithmetic for the current instruction.
//   pc        address of the current instruction
//   offset    signed word offset of the current instruction
//   jump, branch, bne, zero   resolution flags
//   pc_plus4  sequential successor
//   target    redirect address pc + 4 + (sext(offset) << 2), wrapping modulo 2^ADDR_W
//   taken     the current instruction redirects the PC
module next_pc_calc
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 8
) (
    input  logic [ADDR_W-1:0]   pc,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                jump,
    input  logic                branch,
    input  logic                bne,
    input  logic                zero,
    output logic [ADDR_W-1:0]   pc_plus4,
    output logic [ADDR_W-1:0]   target,
    output logic                taken
);

    logic [ADDR_W-1:0] offset_ext;

    // Sign-extend the word offset to the address width.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_sext
            if (gi < OFFSET_W) begin : g_low
                assign offset_ext[gi] = offset[gi];
            end else begin : g_high
                assign offset_ext[gi] = offset[OFFSET_W-1];
            end
        end
    endgenerate

    assign pc_plus4 = pc + ADDR_W'(PC_STEP);
    assign target   = pc_plus4 + (offset_ext << OFFSET_SHIFT);
    assign taken    = jump | (branch & zero) | (bne & ~zero);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter and sequences instruction-memory reads. One
// instruction at a time is presented to decode while the next sequential
// word is prefetched; taken JUMP/BEQ/BNE redirects discard the prefetch.
// Ports:
//   CLK, RESET          clock and synchronous active-high reset
//   imem                instruction-memory read bus (master side)
//   INSTR, INSTR_VALID  current instruction and its valid flag
//   PC                  address of INSTR
//   STALL               execute not finished; hold the current instruction
//   JUMP, BRANCH, BNE, ZERO, OFFSET   resolution of the current instruction,
//                       only looked at when it retires
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int INSTR_W  = 32,
    parameter int OFFSET_W = 8
) (
    input  logic                CLK,
    input  logic                RESET,
    fetch_sequencer_if.master   imem,
    output logic [INSTR_W-1:0]  INSTR,
    output logic                INSTR_VALID,
    output logic [ADDR_W-1:0]   PC,
    input  logic                STALL,
    input  logic                JUMP,
    input  logic                BRANCH,
    input  logic                BNE,
    input  logic                ZERO,
    input  logic [OFFSET_W-1:0] OFFSET
);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W-1:0]  pf_addr_reg, pf_addr_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [INSTR_W-1:0] pfbuf_reg, pfbuf_next;

    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  target;
    logic [ADDR_W-1:0]  pf_addr_plus4;
    logic               taken;
    logic               retire;
    logic               done;

    next_pc_calc #(
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) u_next_pc_calc (
        .pc       (pc_reg),
        .offset   (OFFSET),
        .jump     (JUMP),
        .branch   (BRANCH),
        .bne      (BNE),
        .zero     (ZERO),
        .pc_plus4 (pc_plus4),
        .target   (target),
        .taken    (taken)
    );

    // Address of the prefetch that follows a sequential retire which
    // completes its own prefetch in the same cycle.
    assign pf_addr_plus4 = pf_addr_reg + ADDR_W'(PC_STEP);

    // Outputs depend only on registers, never on memory or execute inputs.
    assign INSTR_VALID    = (state_reg == EXEC) || (state_reg == EXEC_BUF);
    assign imem.IMEM_READ = (state_reg == FETCH) || (state_reg == EXEC) ||
                            (state_reg == DRAIN);
    // In EXEC pf_addr_reg == pc_reg + 4, so an EXEC -> FETCH hand-over after a
    // sequential retire keeps the outstanding address unchanged.
    assign imem.IMEM_ADDR = ((state_reg == EXEC) || (state_reg == DRAIN)) ?
                            pf_addr_reg : pc_reg;
    assign INSTR          = instr_reg;
    assign PC             = pc_reg;

    assign retire = INSTR_VALID & ~STALL;
    assign done   = imem.IMEM_READ & ~imem.IMEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg   <= IDLE;
            pc_reg      <= ADDR_W'(PC_RESET);
            pf_addr_reg <= ADDR_W'(PC_RESET + PC_STEP);
            instr_reg   <= '0;
            pfbuf_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pf_addr_reg <= pf_addr_next;
            instr_reg   <= instr_next;
            pfbuf_reg   <= pfbuf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pf_addr_next = pf_addr_reg;
        instr_next   = instr_reg;
        pfbuf_next   = pfbuf_reg;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                if (done) begin
                    instr_next   = imem.IMEM_RDATA;
                    pf_addr_next = pc_plus4;
                    state_next   = EXEC;
                end
            end

            EXEC: begin
                if (retire) begin
                    if (taken) begin
                        // Any prefetch is stale, even a jump to PC+4.
                        // An in-flight one must finish before re-addressing.
                        pc_next    = target;
                        state_next = done ? FETCH : DRAIN;
                    end else begin
                        pc_next = pc_plus4;
                        if (done) begin
                            instr_next   = imem.IMEM_RDATA;
                            pf_addr_next = pf_addr_plus4;
                        end else begin
                            state_next = FETCH;
                        end
                    end
                end else if (done) begin
                    // Prefetch landed while execute is stalled: park it.
                    pfbuf_next = imem.IMEM_RDATA;
                    state_next = EXEC_BUF;
                end
            end

            EXEC_BUF: begin
                if (retire) begin
                    if (taken) begin
                        pc_next    = target;
                        state_next = FETCH;
                    end else begin
                        pc_next      = pc_plus4;
                        instr_next   = pfbuf_reg;
                        pf_addr_next = pf_addr_plus4;
                        state_next   = EXEC;
                    end
                end
            end

            DRAIN: begin
                // Let the stale prefetch complete, then fetch the target.
                if (done) begin
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Self-checking bench for fetch_sequencer. Instruction memory returns
// word == address after a programmable number of busy cycles. Control-flow
// instructions are modelled by a small table of sites keyed on PC. Every
// retire is compared against a scoreboard of expected addresses, and the
// read request is checked to stay up with a stable address while busy.
module tb_fetch_sequencer;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        JUMP, BRANCH, BNE, ZERO;
    logic [7:0]  OFFSET;
    logic [31:0] INSTR;
    logic        INSTR_VALID;
    logic [31:0] PC;

    fetch_sequencer_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    fetch_sequencer #(.ADDR_W(32), .INSTR_W(32), .OFFSET_W(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .imem        (imem),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .PC          (PC),
        .STALL       (STALL),
        .JUMP        (JUMP),
        .BRANCH      (BRANCH),
        .BNE         (BNE),
        .ZERO        (ZERO),
        .OFFSET      (OFFSET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // ---------------- instruction memory model ----------------
    int mem_wait = 0;
    int wait_cnt = 0;

    assign imem.IMEM_RDATA    = imem.IMEM_ADDR;
    assign imem.IMEM_BUSYWAIT = imem.IMEM_READ && (wait_cnt < mem_wait);

    always @(posedge CLK) begin
        if (RESET || !imem.IMEM_READ || !imem.IMEM_BUSYWAIT)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    // ---------------- control-flow program sites ----------------
    typedef struct packed {
        logic        en;
        logic [31:0] pc;
        logic        jump;
        logic        branch;
        logic        bne;
        logic        zero;
        logic [7:0]  offset;
    } site_t;

    site_t sites [2];

    always_comb begin
        JUMP   = 1'b0;
        BRANCH = 1'b0;
        BNE    = 1'b0;
        ZERO   = 1'b0;
        OFFSET = 8'h00;
        for (int i = 0; i < 2; i++) begin
            if (sites[i].en && PC == sites[i].pc) begin
                JUMP   = sites[i].jump;
                BRANCH = sites[i].branch;
                BNE    = sites[i].bne;
                ZERO   = sites[i].zero;
                OFFSET = sites[i].offset;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard of retired instructions ----------------
    logic [31:0] sb_q [$];
    logic        sb_en = 1'b0;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = '0;

    always @(negedge CLK) begin
        logic [31:0] exp_pc;
        if (sb_en && !RESET && INSTR_VALID && !STALL) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got pc %h expected none", PC);
            end else begin
                exp_pc = sb_q.pop_front();
                check("retire_pc", PC, exp_pc);
                check("retire_instr", INSTR, exp_pc);
                $display("retire pc=%h instr=%h", PC, INSTR);
            end
        end
        // A busy request must still be up with the same address one cycle later.
        if (pend) begin
            check("req_held", {31'b0, imem.IMEM_READ}, 32'd1);
            check("addr_held", imem.IMEM_ADDR, pend_addr);
        end
        pend      <= imem.IMEM_READ && imem.IMEM_BUSYWAIT && !RESET;
        pend_addr <= imem.IMEM_ADDR;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input int w);
        sb_en = 1'b0;
        sb_q.delete();
        STALL = 1'b0;
        RESET = 1'b1;
        mem_wait = w;
        step();
        step();
    endtask

    task automatic push(input logic [31:0] a);
        sb_q.push_back(a);
    endtask

    task automatic wait_pc(input logic [31:0] target, input string name);
        int n = 0;
        while (!(INSTR_VALID === 1'b1 && PC === target) && n < 200) begin
            step();
            n++;
        end
        check({name, "_reached"}, PC, target);
    endtask

    task automatic drain_sb(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        check({name, "_sb_left"}, 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;
        sb_q.delete();
    endtask

    // ---------------- cycle vectors ----------------
    typedef struct {
        logic        stall;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t vecs [11];

    task automatic run_vectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            STALL = vecs[i].stall;
            step();
            $display("vec %0d stall=%0b read=%0b addr=%h valid=%0b pc=%h instr=%h",
                     i, STALL, imem.IMEM_READ, imem.IMEM_ADDR, INSTR_VALID, PC, INSTR);
            check($sformatf("vec%0d_read", i), {31'b0, imem.IMEM_READ}, {31'b0, vecs[i].exp_read});
            if (vecs[i].exp_read)
                check($sformatf("vec%0d_addr", i), imem.IMEM_ADDR, vecs[i].exp_addr);
            check($sformatf("vec%0d_valid", i), {31'b0, INSTR_VALID}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), INSTR, vecs[i].exp_instr);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait sequential start-up, from the cycle after RESET falls.
        vecs[0]  = '{1'b0, 1'b1, 32'd0,  1'b0, 32'd0,  32'd0};
        vecs[1]  = '{1'b0, 1'b1, 32'd4,  1'b1, 32'd0,  32'd0};
        vecs[2]  = '{1'b0, 1'b1, 32'd8,  1'b1, 32'd4,  32'd4};
        vecs[3]  = '{1'b0, 1'b1, 32'd12, 1'b1, 32'd8,  32'd8};
        vecs[4]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12, 32'd12};
        // STALL for 4 cycles at PC=8; prefetch of 12 lands immediately.
        vecs[5]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd8};
        vecs[6]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd8};
        vecs[7]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd8};
        vecs[8]  = '{1'b1, 1'b0, 32'd0,  1'b1, 32'd8,  32'd8};
        vecs[9]  = '{1'b0, 1'b1, 32'd16, 1'b1, 32'd12, 32'd12};
        vecs[10] = '{1'b0, 1'b1, 32'd20, 1'b1, 32'd16, 32'd16};

        sites[0] = '0;
        sites[1] = '0;
        RESET = 1'b1;
        STALL = 1'b0;

        // ---- reset state, then zero-wait sequential fetch ----
        start(0);
        check("rst_read",  {31'b0, imem.IMEM_READ}, 32'd0);
        check("rst_addr",  imem.IMEM_ADDR, 32'd0);
        check("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("rst_pc",    PC, 32'd0);
        check("rst_instr", INSTR, 32'd0);
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'd0); push(32'd4); push(32'd8); push(32'd12);
        run_vectors(0, 4);
        drain_sb("seq0");

        // ---- 3 busy cycles per read: valid once every 4 cycles ----
        start(3);
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'd0); push(32'd4); push(32'd8);
        wait_pc(32'd0, "wait3_first");
        for (int i = 0; i < 12; i++) begin
            check($sformatf("wait3_valid%0d", i), {31'b0, INSTR_VALID}, {31'b0, (i % 4) == 0});
            step();
        end
        drain_sb("wait3");

        // ---- STALL at PC=8 with prefetch buffered ----
        start(0);
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'd0); push(32'd4); push(32'd8); push(32'd12); push(32'd16);
        wait_pc(32'd8, "stall_at8");
        run_vectors(5, 10);
        drain_sb("stall");

        // ---- BEQ at 8 (ZERO=1, OFFSET=-3) with prefetch of 12 still busy ----
        start(2);
        sites[0] = '{1'b1, 32'd8, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFD};
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'd0); push(32'd4); push(32'd8); push(32'd0); push(32'd4);
        wait_pc(32'd8, "beq_at8");
        step();
        check("beq_drain_read",  {31'b0, imem.IMEM_READ}, 32'd1);
        check("beq_drain_addr",  imem.IMEM_ADDR, 32'd12);
        check("beq_drain_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("beq_drain_pc",    PC, 32'd0);
        for (int n = 0; n < 20 && imem.IMEM_ADDR === 32'd12; n++) step();
        check("beq_refetch_addr",  imem.IMEM_ADDR, 32'd0);
        check("beq_refetch_read",  {31'b0, imem.IMEM_READ}, 32'd1);
        check("beq_refetch_valid", {31'b0, INSTR_VALID}, 32'd0);
        drain_sb("beq");
        sites[0] = '0;

        // ---- BNE at 0x10 (ZERO=0, OFFSET=+127) -> 0x210, one bubble ----
        start(0);
        sites[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h7F};
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
        push(32'h210); push(32'h214);
        wait_pc(32'h10, "bne_at10");
        step();
        check("bne_bubble_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("bne_bubble_addr",  imem.IMEM_ADDR, 32'h210);
        check("bne_bubble_pc",    PC, 32'h210);
        step();
        check("bne_target_valid", {31'b0, INSTR_VALID}, 32'd1);
        check("bne_target_instr", INSTR, 32'h210);
        drain_sb("bne");
        sites[0] = '0;

        // ---- JUMP 0 -> 0xFFFFFFFC, then JUMP +0 there wraps to 0 ----
        start(0);
        sites[0] = '{1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE};
        sites[1] = '{1'b1, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'h0); push(32'hFFFFFFFC); push(32'h0); push(32'hFFFFFFFC);
        wait_pc(32'hFFFFFFFC, "jmp_top");
        step();
        check("wrap_bubble_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("wrap_pc",           PC, 32'h0);
        check("wrap_addr",         imem.IMEM_ADDR, 32'h0);
        step();
        check("wrap_target_valid", {31'b0, INSTR_VALID}, 32'd1);
        drain_sb("wrap");
        sites[0] = '0;
        sites[1] = '0;

        // ---- RESET while a read is busy aborts it ----
        start(3);
        RESET = 1'b0;
        step();
        step();
        check("abort_pre_read", {31'b0, imem.IMEM_READ}, 32'd1);
        check("abort_pre_busy", {31'b0, imem.IMEM_BUSYWAIT}, 32'd1);
        RESET = 1'b1;
        step();
        check("abort_read",  {31'b0, imem.IMEM_READ}, 32'd0);
        check("abort_valid", {31'b0, INSTR_VALID}, 32'd0);
        check("abort_pc",    PC, 32'd0);
        RESET = 1'b0;
        sb_en = 1'b1;
        push(32'd0); push(32'd4);
        step();
        check("restart_read", {31'b0, imem.IMEM_READ}, 32'd1);
        check("restart_addr", imem.IMEM_ADDR, 32'd0);
        drain_sb("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
